// File: rtl/prog_rule_array_pkg.sv
// Shared types and sizing helpers for the programmable rule array.
// Default geometry: 5 inputs, 10 product terms, 5 outputs.
package prog_rule_array_pkg;

  localparam int N_IN_DEF   = 5;
  localparam int N_RULE_DEF = 10;
  localparam int N_OUT_DEF  = 5;

  // Control FSM: RUN accepts vectors, DRAIN empties the pipeline before a
  // config write, WRITE performs the single-cycle write handshake.
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    WRITE = 2'd2
  } state_e;

  // Layout of a rule word on the config bus for the default geometry:
  // care mask in the upper half, match value in the lower half.
  typedef struct packed {
    logic [N_IN_DEF-1:0] care;
    logic [N_IN_DEF-1:0] value;
  } rule_t;

  // Address width covering all rule slots followed by all OR rows.
  function automatic int cfg_aw(input int n_rule, input int n_out);
    return ((n_rule + n_out) > 1) ? $clog2(n_rule + n_out) : 1;
  endfunction

  // Data width wide enough for either a rule word or an OR row.
  function automatic int cfg_dw(input int n_in, input int n_rule);
    return ((2 * n_in) > n_rule) ? (2 * n_in) : n_rule;
  endfunction

endpackage

// File: rtl/prog_rule_array_rule_match.sv
// Single product term: combinational hit of one care/value mask pair.
// A care bit of 0 makes that input a don't-care; an all-zero care mask
// therefore always hits.
module rule_match
  import prog_rule_array_pkg::*;
#(
  parameter int N_IN = N_IN_DEF
) (
  input  logic [N_IN-1:0] data_i,
  input  logic [N_IN-1:0] care_i,
  input  logic [N_IN-1:0] value_i,
  output logic            hit_o
);

  assign hit_o = ~|((data_i ^ value_i) & care_i);

endmodule

// File: rtl/prog_rule_array.sv
// Programmable two-stage sum-of-products array.
//   S1 registers the raw term hits, S2 registers the OR-plane result.
//   Config writes are only performed once the pipeline has drained, so every
//   vector in flight is evaluated entirely against the config it entered with.
// Optional feature macro: RULE_HITS_EN adds output out_hits (raw term hits
// aligned with out_data). Without it the port and its S2 register are absent.
module prog_rule_array
  import prog_rule_array_pkg::*;
#(
  parameter  int N_IN   = N_IN_DEF,
  parameter  int N_RULE = N_RULE_DEF,
  parameter  int N_OUT  = N_OUT_DEF,
  localparam int CFG_AW = cfg_aw(N_RULE, N_OUT),
  localparam int CFG_DW = cfg_dw(N_IN, N_RULE)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CFG_AW-1:0] cfg_addr,
  input  logic [CFG_DW-1:0] cfg_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N_IN-1:0]   in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N_OUT-1:0]  out_data
`ifdef RULE_HITS_EN
  ,
  output logic [N_RULE-1:0] out_hits
`endif
);

  state_e             state_q;
  logic               cfg_ready_q;
  logic               s1_v_q;
  logic               s2_v_q;
  logic [N_RULE-1:0]  hit_q;
  logic [N_OUT-1:0]   out_data_q;
  logic [N_RULE-1:0]  hit_d;
  logic [N_OUT-1:0]   out_data_d;
  logic               s2_load;
  logic               s1_load;
  logic               in_accept;
  logic               cfg_wr;

  // S2 can take new data when empty or when its result leaves this cycle;
  // S1 can take new data when empty or when it hands off to S2.
  assign s2_load   = !s2_v_q || out_ready;
  assign s1_load   = !s1_v_q || s2_load;
  // A pending config request blocks new vectors in the same cycle.
  assign in_ready  = (state_q == RUN) && !cfg_valid && s1_load;
  assign in_accept = in_valid && in_ready;
  assign cfg_wr    = cfg_valid && cfg_ready_q;

  assign cfg_ready = cfg_ready_q;
  assign out_valid = s2_v_q;
  assign out_data  = out_data_q;

  // Rule storage and AND-plane: one care/value pair and matcher per term.
  for (genvar gi = 0; gi < N_RULE; gi++) begin : g_rule
    logic [N_IN-1:0] care_q;
    logic [N_IN-1:0] value_q;

    // Load this term's masks when its address is written.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        care_q  <= '0;
        value_q <= '0;
      end else if (cfg_wr && (cfg_addr == CFG_AW'(gi))) begin
        care_q  <= cfg_data[2*N_IN-1:N_IN];
        value_q <= cfg_data[N_IN-1:0];
      end
    end

    rule_match #(
      .N_IN (N_IN)
    ) u_match (
      .data_i  (in_data),
      .care_i  (care_q),
      .value_i (value_q),
      .hit_o   (hit_d[gi])
    );
  end

  // OR-plane: each output row selects a subset of the registered hits.
  for (genvar gi = 0; gi < N_OUT; gi++) begin : g_row
    logic [N_RULE-1:0] row_q;

    // Load this output's term-select row when its address is written.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        row_q <= '0;
      end else if (cfg_wr && (cfg_addr == CFG_AW'(N_RULE + gi))) begin
        row_q <= cfg_data[N_RULE-1:0];
      end
    end

    assign out_data_d[gi] = |(row_q & hit_q);
  end

  // Control FSM: drain the pipeline before any write, then pulse cfg_ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      cfg_ready_q <= 1'b0;
    end else begin
      cfg_ready_q <= 1'b0;
      case (state_q)
        RUN: begin
          if (cfg_valid) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (!cfg_valid) begin
            state_q <= RUN;
          end else if (!s1_v_q && !s2_v_q) begin
            state_q     <= WRITE;
            cfg_ready_q <= 1'b1;
          end
        end
        WRITE: begin
          state_q <= RUN;
        end
        default: begin
          state_q <= RUN;
        end
      endcase
    end
  end

  // Stage 1: capture term hits of an accepted vector.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v_q <= 1'b0;
      hit_q  <= '0;
    end else if (s1_load) begin
      s1_v_q <= in_accept;
      if (in_accept) begin
        hit_q <= hit_d;
      end
    end
  end

  // Stage 2: capture the OR-plane result; holds while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_v_q     <= 1'b0;
      out_data_q <= '0;
    end else if (s2_load) begin
      s2_v_q <= s1_v_q;
      if (s1_v_q) begin
        out_data_q <= out_data_d;
      end
    end
  end

`ifdef RULE_HITS_EN
  logic [N_RULE-1:0] hits_s2_q;

  // Raw hits travel alongside out_data with the same stall behaviour.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hits_s2_q <= '0;
    end else if (s2_load && s1_v_q) begin
      hits_s2_q <= hit_q;
    end
  end

  assign out_hits = hits_s2_q;
`endif

endmodule
